dmem_arb: RTL and testbench

Arbiter and sequencer for the single-port data memory (dmem). It shares dmem between the pipeline memory-access stage (requester P) and a debug/loader port (requester D). The pipeline has fixed priority, bounded by a starvation limit for D, and D can lock the pipeline out entirely. The block sits between the MA stage, the debug port and dmem, and produces the pipeline stall for memory-access conflicts.

---
 rtl/dmem_arb.sv | 99 +++++++++
 tb/tb_dmem_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arb.sv
// dmem_arb: shares the single-port data memory between the MA stage (P)
// and the debug/loader port (D), with a starvation bound and a debug lock.
module dmem_arb #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 24,
   parameter int STARVE_MAX = 4
) (
   input  logic              iw_clk,
   input  logic              iw_rst,
   input  logic              iw_p_req,
   input  logic              iw_p_we,
   input  logic [ADDR_W-1:0] iw_p_addr,
   input  logic [DATA_W-1:0] iw_p_wdata,
   output logic              ow_p_gnt,
   output logic              ow_p_stall,
   output logic              ow_p_rvalid,
   output logic [DATA_W-1:0] ow_p_rdata,
   input  logic              iw_d_req,
   input  logic              iw_d_we,
   input  logic [ADDR_W-1:0] iw_d_addr,
   input  logic [DATA_W-1:0] iw_d_wdata,
   input  logic              iw_d_lock,
   output logic              ow_d_gnt,
   output logic              ow_d_rvalid,
   output logic [DATA_W-1:0] ow_d_rdata,
   output logic              ow_locked,
   output logic              ow_mem_en,
   output logic              ow_mem_we,
   output logic [ADDR_W-1:0] ow_mem_addr,
   output logic [DATA_W-1:0] ow_mem_wdata,
   input  logic [DATA_W-1:0] iw_mem_rdata
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   typedef enum logic {NORMAL, LOCK} state_t;

   state_t            state;
   logic [3:0]        starve;
   logic              own_p;
   logic              own_d;
   logic [DATA_W-1:0] p_hold;
   logic [DATA_W-1:0] d_hold;
   logic              p_win;
   logic              d_win;

   // Grants are forced low while reset is held.
   always_comb begin
      p_win = 1'b0;
      d_win = 1'b0;
      if (!iw_rst) begin
         if (state == LOCK) begin
            d_win = iw_d_req;
         end else begin
            d_win = iw_d_req && (!iw_p_req || starve == SMAX);
            p_win = iw_p_req && !d_win;
         end
      end
   end

   assign ow_p_gnt     = p_win;
   assign ow_d_gnt     = d_win;
   assign ow_p_stall   = iw_p_req && !p_win;
   assign ow_locked    = (state == LOCK);
   assign ow_mem_en    = p_win || d_win;
   assign ow_mem_we    = d_win ? iw_d_we : (p_win && iw_p_we);
   assign ow_mem_addr  = d_win ? iw_d_addr : iw_p_addr;
   assign ow_mem_wdata = d_win ? iw_d_wdata : iw_p_wdata;

   assign ow_p_rvalid = own_p;
   assign ow_d_rvalid = own_d;
   assign ow_p_rdata  = own_p ? iw_mem_rdata : p_hold;
   assign ow_d_rdata  = own_d ? iw_mem_rdata : d_hold;

   always_ff @(posedge iw_clk or posedge iw_rst) begin
      if (iw_rst) begin
         state  <= NORMAL;
         starve <= '0;
         own_p  <= 1'b0;
         own_d  <= 1'b0;
         p_hold <= '0;
         d_hold <= '0;
      end else begin
         state <= iw_d_lock ? LOCK : NORMAL;
         if (d_win || !iw_d_req)
            starve <= '0;
         else if (starve != SMAX)
            starve <= starve + 4'd1;
         own_p <= p_win && !iw_p_we;
         own_d <= d_win && !iw_d_we;
         // Returned data is latched so the output holds between reads.
         if (own_p)
            p_hold <= iw_mem_rdata;
         if (own_d)
            d_hold <= iw_mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arb.sv
// tb_dmem_arb: directed + randomized checks of dmem_arb against a
// cycle-level behavioural model and a bench-side dmem.
module tb_dmem_arb;

   localparam int AW = 10;
   localparam int DW = 24;
   localparam int SM = 4;

   logic          r_clk = 1'b0;
   logic          rst;
   logic          p_req, p_we, d_req, d_we, d_lock;
   logic [AW-1:0] p_addr, d_addr;
   logic [DW-1:0] p_wdata, d_wdata;
   logic          p_gnt, p_stall, p_rvalid;
   logic [DW-1:0] p_rdata;
   logic          d_gnt, d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          locked, mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_init;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 r_clk = ~r_clk;

   dmem_arb #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
      .iw_clk(r_clk), .iw_rst(rst),
      .iw_p_req(p_req), .iw_p_we(p_we), .iw_p_addr(p_addr),
      .iw_p_wdata(p_wdata), .ow_p_gnt(p_gnt), .ow_p_stall(p_stall),
      .ow_p_rvalid(p_rvalid), .ow_p_rdata(p_rdata),
      .iw_d_req(d_req), .iw_d_we(d_we), .iw_d_addr(d_addr),
      .iw_d_wdata(d_wdata), .iw_d_lock(d_lock),
      .ow_d_gnt(d_gnt), .ow_d_rvalid(d_rvalid), .ow_d_rdata(d_rdata),
      .ow_locked(locked), .ow_mem_en(mem_en), .ow_mem_we(mem_we),
      .ow_mem_addr(mem_addr), .ow_mem_wdata(mem_wdata),
      .iw_mem_rdata(mem_rdata)
   );

   function automatic logic [DW-1:0] init_val(input int a);
      if (a == 5) return 24'h00ABCD;
      return DW'(a * 40503 + 4660);
   endfunction

   // Bench-side single-port dmem with one cycle read latency.
   logic [DW-1:0] mem [1024];
   always @(posedge r_clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= init_val(i);
         mem_rdata <= '0;
      end else if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   // Behavioural model: owner 0=none 1=P 2=D.
   logic [DW-1:0] shadow [1024];
   int            m_lock, m_starve, m_own;
   logic [DW-1:0] m_data, m_prd, m_drd;
   int            n_lock, n_starve, n_own;
   logic [DW-1:0] n_data, n_prd, n_drd;
   logic          n_wr;
   logic [AW-1:0] n_wa;
   logic [DW-1:0] n_wd;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_lock = 0; m_starve = 0; m_own = 0; m_data = '0;
      m_prd = '0; m_drd = '0;
      n_lock = 0; n_starve = 0; n_own = 0; n_data = '0;
      n_prd = '0; n_drd = '0; n_wr = 1'b0; n_wa = '0; n_wd = '0;
   endtask

   task automatic commit();
      if (n_wr) shadow[n_wa] = n_wd;
      m_lock = n_lock; m_starve = n_starve; m_own = n_own;
      m_data = n_data; m_prd = n_prd; m_drd = n_drd;
   endtask

   task automatic model_check();
      bit eg_p, eg_d, e_en, e_we, prv, drv;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew, epr, edr;
      if (m_lock != 0) begin
         eg_d = d_req;
         eg_p = 1'b0;
      end else begin
         eg_d = d_req && (!p_req || m_starve == SM);
         eg_p = p_req && !eg_d;
      end
      e_en = eg_p || eg_d;
      e_we = eg_d ? d_we : (eg_p && p_we);
      ea   = eg_d ? d_addr : p_addr;
      ew   = eg_d ? d_wdata : p_wdata;
      prv  = (m_own == 1);
      drv  = (m_own == 2);
      epr  = prv ? m_data : m_prd;
      edr  = drv ? m_data : m_drd;
      chk("p_gnt", 64'(p_gnt), 64'(eg_p));
      chk("d_gnt", 64'(d_gnt), 64'(eg_d));
      chk("p_stall", 64'(p_stall), 64'(p_req && !eg_p));
      chk("locked", 64'(locked), 64'(m_lock != 0));
      chk("mem_en", 64'(mem_en), 64'(e_en));
      chk("mem_we", 64'(mem_we), 64'(e_we));
      if (e_en) begin
         chk("mem_addr", 64'(mem_addr), 64'(ea));
         chk("mem_wdata", 64'(mem_wdata), 64'(ew));
      end
      chk("p_rvalid", 64'(p_rvalid), 64'(prv));
      chk("d_rvalid", 64'(d_rvalid), 64'(drv));
      chk("p_rdata", 64'(p_rdata), 64'(epr));
      chk("d_rdata", 64'(d_rdata), 64'(edr));
      n_lock   = d_lock ? 1 : 0;
      n_starve = (eg_d || !d_req) ? 0
               : ((m_starve + 1 > SM) ? SM : m_starve + 1);
      n_own    = (e_en && !e_we) ? (eg_d ? 2 : 1) : 0;
      n_data   = shadow[ea];
      n_prd    = epr;
      n_drd    = edr;
      n_wr     = e_en && e_we;
      n_wa     = ea;
      n_wd     = ew;
   endtask

   task automatic cyc(input logic pr, input logic pw,
                      input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                      input logic dr, input logic dw,
                      input logic [AW-1:0] da, input logic [DW-1:0] dd,
                      input logic lk);
      @(posedge r_clk);
      #1;
      commit();
      p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
      d_req = dr; d_we = dw; d_addr = da; d_wdata = dd; d_lock = lk;
      #2;
      model_check();
   endtask

   task automatic idle_inputs();
      p_req = 0; p_we = 0; p_addr = '0; p_wdata = '0;
      d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_lock = 0;
   endtask

   task automatic chk_reset_outs(input string nm);
      chk({nm, "_pg"}, 64'(p_gnt), 64'd0);
      chk({nm, "_dg"}, 64'(d_gnt), 64'd0);
      chk({nm, "_en"}, 64'(mem_en), 64'd0);
      chk({nm, "_we"}, 64'(mem_we), 64'd0);
      chk({nm, "_prv"}, 64'(p_rvalid), 64'd0);
      chk({nm, "_drv"}, 64'(d_rvalid), 64'd0);
      chk({nm, "_lk"}, 64'(locked), 64'd0);
      chk({nm, "_prd"}, 64'(p_rdata), 64'd0);
   endtask

   // Reset asserted mid-cycle; the request in progress is dropped.
   task automatic rst_pulse();
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      chk_reset_outs("rst_mid");
      idle_inputs();
      @(posedge r_clk);
      #2;
      chk_reset_outs("rst_hold");
      rst = 1'b0;
   endtask

   logic [9:0] pat;
   bit         lk_hold;

   initial begin
      rst = 1'b1;
      mem_init = 1'b1;
      idle_inputs();
      p_req = 1'b1;
      model_reset();
      for (int i = 0; i < 1024; i++) shadow[i] = init_val(i);
      @(posedge r_clk);
      #1;
      mem_init = 1'b0;
      chk("reset_p_gnt", 64'(p_gnt), 64'd0);
      chk_reset_outs("rst_init");
      p_req = 1'b0;
      @(posedge r_clk);
      #2;
      rst = 1'b0;

      // P read then P write.
      cyc(1, 0, 10'h005, '0, 0, 0, '0, '0, 0);
      chk("lit_p_gnt", 64'(p_gnt), 64'd1);
      chk("lit_addr", 64'(mem_addr), 64'h005);
      chk("lit_we_rd", 64'(mem_we), 64'd0);
      cyc(1, 1, 10'h007, 24'h123456, 0, 0, '0, '0, 0);
      chk("lit_p_rvalid", 64'(p_rvalid), 64'd1);
      chk("lit_p_rdata", 64'(p_rdata), 64'h00ABCD);
      chk("lit_we_wr", 64'(mem_we), 64'd1);
      cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
      chk("lit_wr_norv", 64'(p_rvalid), 64'd0);

      // Reset during a P read: no rvalid afterwards.
      cyc(1, 0, 10'h003, '0, 0, 0, '0, '0, 0);
      rst_pulse();
      cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
      chk("lit_rst_norv", 64'(p_rvalid), 64'd0);
      chk("lit_rst_prd", 64'(p_rdata), 64'd0);

      // Contention: PPPPD PPPPD.
      for (int i = 0; i < 10; i++) begin
         cyc(1, 0, AW'(i), '0, 1, 0, AW'(i + 32), '0, 0);
         pat[i] = d_gnt;
      end
      chk("lit_ppppd", 64'(pat), 64'h210);

      // D only.
      cyc(0, 0, '0, '0, 1, 0, 10'h010, '0, 0);
      chk("lit_d_gnt", 64'(d_gnt), 64'd1);
      cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
      chk("lit_d_rv", 64'(d_rvalid), 64'd1);
      chk("lit_d_rdata", 64'(d_rdata), 64'(init_val(16)));
      chk("lit_d_prv", 64'(p_rvalid), 64'd0);

      // Lock with P requesting continuously.
      cyc(1, 0, 10'h001, '0, 0, 0, '0, '0, 1);
      chk("lit_lk0_pg", 64'(p_gnt), 64'd1);
      chk("lit_lk0_lk", 64'(locked), 64'd0);
      cyc(1, 0, 10'h001, '0, 1, 0, 10'h020, '0, 1);
      chk("lit_lk1_lk", 64'(locked), 64'd1);
      chk("lit_lk1_pg", 64'(p_gnt), 64'd0);
      chk("lit_lk1_st", 64'(p_stall), 64'd1);
      chk("lit_lk1_dg", 64'(d_gnt), 64'd1);
      chk("lit_lk1_prv", 64'(p_rvalid), 64'd1);
      cyc(1, 0, 10'h001, '0, 1, 1, 10'h021, 24'h55AA55, 1);
      chk("lit_lk2_dg", 64'(d_gnt), 64'd1);
      chk("lit_lk2_we", 64'(mem_we), 64'd1);
      chk("lit_lk2_drv", 64'(d_rvalid), 64'd1);
      cyc(1, 0, 10'h001, '0, 0, 0, '0, '0, 0);
      chk("lit_ul0_pg", 64'(p_gnt), 64'd0);
      cyc(1, 0, 10'h001, '0, 0, 0, '0, '0, 0);
      chk("lit_ul1_pg", 64'(p_gnt), 64'd1);
      chk("lit_ul1_lk", 64'(locked), 64'd0);

      // P read then D read back to back.
      cyc(1, 0, 10'h030, '0, 0, 0, '0, '0, 0);
      cyc(0, 0, '0, '0, 1, 0, 10'h031, '0, 0);
      chk("lit_b2b_prv", 64'(p_rvalid), 64'd1);
      chk("lit_b2b_prd", 64'(p_rdata), 64'(init_val(48)));
      chk("lit_b2b_dg", 64'(d_gnt), 64'd1);
      cyc(0, 0, '0, '0, 0, 0, '0, '0, 0);
      chk("lit_b2b_drv", 64'(d_rvalid), 64'd1);
      chk("lit_b2b_drd", 64'(d_rdata), 64'(init_val(49)));
      chk("lit_b2b_prv2", 64'(p_rvalid), 64'd0);

      // Randomized traffic.
      lk_hold = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 29) == 0) lk_hold = !lk_hold;
         cyc($urandom_range(0, 9) < 7, 1'($urandom),
             AW'($urandom_range(0, 15)), DW'($urandom),
             $urandom_range(0, 1) == 1, 1'($urandom),
             AW'($urandom_range(0, 15)), DW'($urandom), lk_hold);
         if ($urandom_range(0, 299) == 0) begin
            rst_pulse();
            lk_hold = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
